// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  // One stored receive character with its line-status bits.
  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam int unsigned ENTRY_W = 11;

  // TRIGLVL encodings.
  localparam logic [1:0] TRIG_SEL_1  = 2'b00;
  localparam logic [1:0] TRIG_SEL_4  = 2'b01;
  localparam logic [1:0] TRIG_SEL_8  = 2'b10;
  localparam logic [1:0] TRIG_SEL_14 = 2'b11;

  // Timeout is four character times of 16x ticks: char_bits * 64.
  localparam int unsigned TIMEOUT_MULT = 64;
  localparam int unsigned TMO_W        = 10;

  // Occupancy threshold for a trigger-level selection.
  function automatic int unsigned trig_level(input logic [1:0] sel);
    int unsigned lvl;
    lvl = 1;
    case (sel)
      TRIG_SEL_1:  lvl = 1;
      TRIG_SEL_4:  lvl = 4;
      TRIG_SEL_8:  lvl = 8;
      TRIG_SEL_14: lvl = 14;
      default:     lvl = 1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: circular buffer with registered head entry and count.
// push appends at the tail, pop advances the head, ovw rewrites the head in place.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             ovw,
  input  rx_entry_t        wdata,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output rx_entry_t        head,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  rx_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr_n;
  logic [PTR_W-1:0] wptr_n;
  logic [PTR_W-1:0] waddr;
  logic             we;
  rx_entry_t        head_n;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);

  // Next pointers/count and the entry that will sit at the head after this edge.
  always_comb begin
    rptr_n      = rptr;
    wptr_n      = wptr;
    count_nxt_c = count;
    we          = 1'b0;
    waddr       = wptr;
    if (clr) begin
      rptr_n      = '0;
      wptr_n      = '0;
      count_nxt_c = '0;
    end else begin
      if (pop)  rptr_n = rptr + PTR_W'(1);
      if (push) wptr_n = wptr + PTR_W'(1);
      count_nxt_c = count + CNT_W'(push) - CNT_W'(pop);
      we          = push | ovw;
      waddr       = ovw ? rptr : wptr;
    end
    head_n = (we && (waddr == rptr_n)) ? wdata : mem_q[rptr_n];
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Pointers, occupancy and the registered head entry (data holds when empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      rptr  <= rptr_n;
      wptr  <= wptr_n;
      count <= count_nxt_c;
      if (count_nxt_c != '0) begin
        head <= head_n;
      end else begin
        head.bi <= 1'b0;
        head.fe <= 1'b0;
        head.pe <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive buffer controller: FIFO / holding register, overrun, error
// summary, trigger level and character timeout.
// Optional: define UART_RX_FIFO_TIMEOUT_EN to build the character-timeout
// counter; otherwise TIMEOUT is tied low and WLS/STB/PEN/BAUDTICK are unused.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BAUDTICK,
  input  logic             RXFINISHED,
  input  logic [7:0]       DIN,
  input  logic             PE_IN,
  input  logic             FE_IN,
  input  logic             BI_IN,
  input  logic             FIFOEN,
  input  logic             FIFOCLR,
  input  logic [1:0]       WLS,
  input  logic             STB,
  input  logic             PEN,
  input  logic [1:0]       TRIGLVL,
  input  logic             RD,
  input  logic             LSRRD,
  output logic [7:0]       RBR,
  output logic             DR,
  output logic             PE,
  output logic             FE,
  output logic             BI,
  output logic             OE,
  output logic             FIFOERR,
  output logic             TRIG,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] COUNT
);

  logic             fifoen_q;
  logic             flush_c;
  logic             rd_ok_c;
  logic             full_c;
  logic             mem_full_c;
  logic             empty_c;
  logic             push_c;
  logic             ovw_c;
  logic             oe_set_c;
  logic             new_err_c;
  logic             head_err_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] err_cnt_n;
  logic [CNT_W-1:0] lvl_c;
  rx_entry_t        wdata_c;
  rx_entry_t        head;

  assign wdata_c = '{bi: BI_IN, fe: FE_IN, pe: PE_IN, data: DIN};

  // Flush, accept/overrun decisions for this cycle.
  always_comb begin
    flush_c    = FIFOCLR | (FIFOEN != fifoen_q);
    full_c     = FIFOEN ? mem_full_c : ~empty_c;
    rd_ok_c    = RD & ~empty_c & ~flush_c;
    push_c     = RXFINISHED & ~flush_c & (~full_c | rd_ok_c);
    oe_set_c   = RXFINISHED & ~flush_c & full_c & ~rd_ok_c;
    ovw_c      = oe_set_c & ~FIFOEN;
    new_err_c  = PE_IN | FE_IN | BI_IN;
    head_err_c = head.pe | head.fe | head.bi;
  end

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_mem (
    .clk         (CLK),
    .rst         (RST),
    .clr         (flush_c),
    .push        (push_c),
    .pop         (rd_ok_c),
    .ovw         (ovw_c),
    .wdata       (wdata_c),
    .count       (COUNT),
    .count_nxt_c (count_nxt_c),
    .head        (head),
    .full_c      (mem_full_c),
    .empty_c     (empty_c)
  );

  assign RBR = head.data;
  assign PE  = head.pe;
  assign FE  = head.fe;
  assign BI  = head.bi;

  // Error-entry count and clamped trigger threshold.
  always_comb begin
    err_cnt_n = err_cnt;
    if (flush_c) begin
      err_cnt_n = '0;
    end else begin
      err_cnt_n = err_cnt
                + CNT_W'((push_c | ovw_c) & new_err_c)
                - CNT_W'((rd_ok_c | ovw_c) & head_err_c);
    end
    lvl_c = (trig_level(TRIGLVL) > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(trig_level(TRIGLVL));
  end

  // Status registers: mode history, overrun, data-ready, error and trigger flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifoen_q <= 1'b0;
      OE       <= 1'b0;
      DR       <= 1'b0;
      err_cnt  <= '0;
      FIFOERR  <= 1'b0;
      TRIG     <= 1'b0;
    end else begin
      fifoen_q <= FIFOEN;
      if (oe_set_c)   OE <= 1'b1;
      else if (LSRRD) OE <= 1'b0;
      DR      <= (count_nxt_c != '0);
      err_cnt <= err_cnt_n;
      FIFOERR <= (err_cnt_n != '0);
      TRIG    <= FIFOEN & (count_nxt_c >= lvl_c);
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_cnt_n;
  logic [TMO_W-1:0] limit_c;
  logic [3:0]       char_bits_c;

  // Four character times of idle with data waiting, counted in 16x ticks.
  always_comb begin
    char_bits_c = 4'd7 + 4'(WLS) + 4'(PEN) + 4'(STB);
    limit_c     = TMO_W'(char_bits_c) * TMO_W'(TIMEOUT_MULT);
    tmo_cnt_n   = tmo_cnt;
    if (flush_c | push_c | ovw_c | rd_ok_c | empty_c) begin
      tmo_cnt_n = '0;
    end else if (BAUDTICK & FIFOEN & (tmo_cnt < limit_c)) begin
      tmo_cnt_n = tmo_cnt + TMO_W'(1);
    end
  end

  // Timeout counter and saturating indication.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt <= '0;
      TIMEOUT <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
      TIMEOUT <= (tmo_cnt_n >= limit_c);
    end
  end
`else
  logic unused_tmo_inputs;
  assign unused_tmo_inputs = ^{WLS, STB, PEN, BAUDTICK};
  assign TIMEOUT           = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_uart_rx_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic             BAUDTICK, RXFINISHED, PE_IN, FE_IN, BI_IN;
  logic [7:0]       DIN;
  logic             FIFOEN, FIFOCLR, STB, PEN, RD, LSRRD;
  logic [1:0]       WLS, TRIGLVL;
  logic [7:0]       RBR;
  logic             DR, PE, FE, BI, OE, FIFOERR, TRIG, TIMEOUT;
  logic [CNT_W-1:0] COUNT;

  uart_rx_fifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .BAUDTICK(BAUDTICK), .RXFINISHED(RXFINISHED),
    .DIN(DIN), .PE_IN(PE_IN), .FE_IN(FE_IN), .BI_IN(BI_IN),
    .FIFOEN(FIFOEN), .FIFOCLR(FIFOCLR), .WLS(WLS), .STB(STB), .PEN(PEN),
    .TRIGLVL(TRIGLVL), .RD(RD), .LSRRD(LSRRD), .RBR(RBR), .DR(DR),
    .PE(PE), .FE(FE), .BI(BI), .OE(OE), .FIFOERR(FIFOERR), .TRIG(TRIG),
    .TIMEOUT(TIMEOUT), .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: stored characters as {bi,fe,pe,data}.
  logic [10:0] mq[$];
  bit          m_oe, m_trig, m_tmo, m_fen_prev;
  logic [7:0]  m_rbr;
  int          m_ticks;

  task automatic model_reset();
    mq.delete();
    m_oe = 0; m_trig = 0; m_tmo = 0; m_fen_prev = 0; m_rbr = 8'h00; m_ticks = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit flush, rdok, full, ovr, acc;
    int cap, lvl, lim, sz0;
    flush = FIFOCLR || (FIFOEN != m_fen_prev);
    m_fen_prev = FIFOEN;
    sz0 = mq.size();
    rdok = 0; ovr = 0; acc = 0;
    if (flush) begin
      mq.delete();
    end else begin
      cap  = FIFOEN ? DEPTH : 1;
      rdok = RD && (sz0 > 0);
      full = sz0 >= cap;
      ovr  = RXFINISHED && full && !rdok;
      if (rdok) void'(mq.pop_front());
      if (RXFINISHED) begin
        acc = 1;
        if (!ovr)         mq.push_back({BI_IN, FE_IN, PE_IN, DIN});
        else if (!FIFOEN) mq[0] = {BI_IN, FE_IN, PE_IN, DIN};
        else              acc = 0;
      end
    end
    if (ovr)        m_oe = 1;
    else if (LSRRD) m_oe = 0;
    if (mq.size() > 0) m_rbr = mq[0][7:0];
    case (TRIGLVL)
      2'd0: lvl = 1;
      2'd1: lvl = 4;
      2'd2: lvl = 8;
      default: lvl = 14;
    endcase
    if (lvl > DEPTH) lvl = DEPTH;
    m_trig = FIFOEN && (mq.size() >= lvl);
    lim = (7 + int'(WLS) + int'(PEN) + int'(STB)) * 64;
    if (flush || acc || rdok || sz0 == 0)            m_ticks = 0;
    else if (BAUDTICK && FIFOEN && m_ticks < lim)    m_ticks++;
    m_tmo = TMO_EN && (m_ticks >= lim);
  endtask

  task automatic compare_all();
    bit ferr;
    bit ne;
    ferr = 0;
    foreach (mq[i]) if (|mq[i][10:8]) ferr = 1;
    ne = mq.size() > 0;
    check("COUNT",   32'(COUNT), 32'(mq.size()));
    check("DR",      32'(DR),    32'(ne));
    check("RBR",     32'(RBR),   32'(m_rbr));
    check("PE",      32'(PE),    ne ? 32'(mq[0][8])  : 32'd0);
    check("FE",      32'(FE),    ne ? 32'(mq[0][9])  : 32'd0);
    check("BI",      32'(BI),    ne ? 32'(mq[0][10]) : 32'd0);
    check("OE",      32'(OE),    32'(m_oe));
    check("FIFOERR", 32'(FIFOERR), 32'(ferr));
    check("TRIG",    32'(TRIG),  32'(m_trig));
    check("TIMEOUT", 32'(TIMEOUT), 32'(m_tmo));
  endtask

  // One clock: apply inputs, step the model at the edge, compare just after.
  task automatic cyc(input bit rx, input logic [7:0] d, input logic [2:0] err,
                     input bit rd, input bit lsr, input bit clr, input bit bt);
    RXFINISHED = rx; DIN = d; {BI_IN, FE_IN, PE_IN} = err;
    RD = rd; LSRRD = lsr; FIFOCLR = clr; BAUDTICK = bt;
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
    @(negedge CLK);
    RXFINISHED = 0; RD = 0; LSRRD = 0; FIFOCLR = 0; BAUDTICK = 0;
  endtask

  task automatic idle();
    cyc(0, 8'h00, 3'b000, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1, d, 3'b000, 0, 0, 0, 0);
  endtask

  task automatic pop();
    cyc(0, 8'h00, 3'b000, 1, 0, 0, 0);
  endtask

  initial begin
    RST = 1; BAUDTICK = 0; RXFINISHED = 0; DIN = 0; PE_IN = 0; FE_IN = 0; BI_IN = 0;
    FIFOEN = 0; FIFOCLR = 0; WLS = 0; STB = 0; PEN = 0; TRIGLVL = 0; RD = 0; LSRRD = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    compare_all();
    check("rst_count", 32'(COUNT), 32'd0);
    RST = 0;

    // Basic FIFO ordering.
    FIFOEN = 1; idle();
    push(8'h41); push(8'h42); push(8'h43);
    check("t1_count", 32'(COUNT), 32'd3);
    check("t1_rbr0", 32'(RBR), 32'h41);
    pop(); check("t1_rbr1", 32'(RBR), 32'h42);
    pop(); check("t1_rbr2", 32'(RBR), 32'h43);
    pop(); check("t1_dr", 32'(DR), 32'd0);
    check("t1_empty", 32'(COUNT), 32'd0);

    // FIFO overrun: 17th character dropped.
    for (int i = 0; i < 17; i++) push(8'(8'h60 + i));
    check("t2_count", 32'(COUNT), 32'd16);
    check("t2_oe", 32'(OE), 32'd1);
    cyc(0, 8'h00, 3'b000, 0, 1, 0, 0);
    check("t2_oe_clr", 32'(OE), 32'd0);
    check("t2_head", 32'(RBR), 32'h60);
    for (int i = 0; i < 15; i++) pop();
    check("t2_last", 32'(RBR), 32'h6F);
    pop();

    // Holding-register mode overwrite and read-suppressed overrun.
    FIFOEN = 0; idle();
    push(8'h55); push(8'hAA);
    check("t3_rbr", 32'(RBR), 32'hAA);
    check("t3_oe", 32'(OE), 32'd1);
    cyc(0, 8'h00, 3'b000, 1, 1, 0, 0);
    push(8'h55);
    cyc(1, 8'hAA, 3'b000, 1, 0, 0, 0);
    check("t3_oe_rd", 32'(OE), 32'd0);
    check("t3_rbr_rd", 32'(RBR), 32'hAA);
    pop();

    // Error summary.
    FIFOEN = 1; idle();
    cyc(1, 8'h00, 3'b110, 0, 0, 0, 0);
    push(8'h33);
    check("t4_ferr", 32'(FIFOERR), 32'd1);
    check("t4_bife", 32'({BI, FE}), 32'd3);
    pop();
    check("t4_rbr", 32'(RBR), 32'h33);
    check("t4_ferr0", 32'(FIFOERR), 32'd0);
    pop();

    // Trigger level 4.
    TRIGLVL = 2'b01;
    push(8'h01); push(8'h02); push(8'h03);
    check("t5_trig0", 32'(TRIG), 32'd0);
    push(8'h04);
    check("t5_trig1", 32'(TRIG), 32'd1);
    pop();
    check("t5_trig2", 32'(TRIG), 32'd0);
    cyc(0, 8'h00, 3'b000, 0, 0, 1, 0);

    // Character timeout, 10-bit characters: 640 ticks.
    WLS = 2'b11; PEN = 0; STB = 0;
    push(8'h77);
    for (int i = 0; i < 639; i++) cyc(0, 8'h00, 3'b000, 0, 0, 0, 1);
    check("t6_tmo_early", 32'(TIMEOUT), 32'd0);
    cyc(0, 8'h00, 3'b000, 0, 0, 0, 1);
    check("t6_tmo_hit", 32'(TIMEOUT), 32'(TMO_EN));
    cyc(0, 8'h00, 3'b000, 1, 0, 0, 1);
    check("t6_tmo_rd", 32'(TIMEOUT), 32'd0);
    push(8'h78);
    for (int i = 0; i < 100; i++) cyc(0, 8'h00, 3'b000, 0, 0, 0, 1);
    cyc(0, 8'h00, 3'b000, 0, 0, 1, 1);
    check("t6_clr_count", 32'(COUNT), 32'd0);
    check("t6_clr_tmo", 32'(TIMEOUT), 32'd0);

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) FIFOEN = ~FIFOEN;
      if ($urandom_range(99) == 0) begin
        TRIGLVL = 2'($urandom); WLS = 2'($urandom);
        PEN = 1'($urandom); STB = 1'($urandom);
      end
      cyc($urandom_range(9) < 4, 8'($urandom),
          ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000,
          $urandom_range(3) == 0, $urandom_range(9) == 0,
          $urandom_range(49) == 0, $urandom_range(1) == 0);
      if (i == 1500) begin
        RST = 1;
        #2;
        model_reset();
        compare_all();
        @(negedge CLK);
        RST = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
Receive-side buffer stage that sits directly downstream of the UART receiver. It captures each completed character together with its PE/FE/BI status into a FIFO (16550 FIFO mode) or a single holding register (16450 mode). It produces the RBR data, the per-character line-status bits, the overrun flag, the trigger-level indication and the character-timeout indication consumed by the register/interrupt logic.

Parameters:
DEPTH, 16, number of FIFO entries; power of two, at least 4.
CNT_W, $clog2(DEPTH)+1, width of the occupancy and error counters.

Ports:
CLK  in  1  system clock.
RST  in  1  reset, asynchronous, active-high.
BAUDTICK  in  1  16x baud enable, one CLK cycle wide.
RXFINISHED  in  1  character complete, one CLK-cycle pulse per character.
DIN  in  8  received character, valid while RXFINISHED=1.
PE_IN  in  1  parity error for the character on DIN.
FE_IN  in  1  framing error for the character on DIN.
BI_IN  in  1  break indication for the character on DIN.
FIFOEN  in  1  1 = FIFO mode, 0 = single holding register.
FIFOCLR  in  1  synchronous flush pulse.
WLS  in  2  word length select (5+WLS data bits).
STB  in  1  stop bit select (0 = one stop bit, 1 = two).
PEN  in  1  parity enable.
TRIGLVL  in  2  trigger level select: 00=1, 01=4, 10=8, 11=14.
RD  in  1  RBR read strobe, one cycle.
LSRRD  in  1  LSR read strobe, one cycle; clears OE.
RBR  out  8  head-entry data.
DR  out  1  data ready; 1 when occupancy is nonzero.
PE  out  1  head-entry parity error bit.
FE  out  1  head-entry framing error bit.
BI  out  1  head-entry break bit.
OE  out  1  overrun flag, sticky.
FIFOERR  out  1  at least one stored entry has PE, FE or BI set.
TRIG  out  1  occupancy has reached the selected trigger level.
TIMEOUT  out  1  character timeout.
COUNT  out  CNT_W  current occupancy.

Behaviour:
- Reset: all outputs 0, pointers 0, counters 0.
- Entry format: {BI,FE,PE,DIN}, 11 bits.
- Push: a cycle with RXFINISHED=1 writes the entry. COUNT, DR and RBR update on the next CLK edge (1-cycle latency).
- Pop: a cycle with RD=1 while COUNT>0 advances the head. The next entry appears on RBR/PE/FE/BI on the next edge. RD while empty is ignored.
- Head outputs with COUNT=0: RBR holds its last value; PE/FE/BI are 0.
- Effective capacity: DEPTH when FIFOEN=1, 1 when FIFOEN=0.
- Full in FIFO mode: push and read in the same cycle are both accepted, with no OE. Push without read sets OE, discards the new character and leaves the FIFO unchanged.
- Full in non-FIFO mode: a push overwrites the holding register and sets OE. A same-cycle RD suppresses OE.
- OE clear: OE clears on LSRRD. If LSRRD coincides with a new overrun, OE stays 1 (set wins).
- FIFOERR: error counter +1 on push of an entry with any error bit, -1 on pop of such an entry; FIFOERR = counter != 0.
- TRIG: COUNT >= level, where level is 1/4/8/14 per TRIGLVL, clamped to DEPTH. Forced to 0 when FIFOEN=0.
- Flush (FIFOCLR, or any change of FIFOEN): clears pointers, COUNT, error counter and timeout state on the next edge. OE is unaffected. Flush beats a same-cycle push or read; the character is dropped with no OE.
- Timeout counter:
  - char_bits = 1 + (5+WLS) + PEN + (1+STB), range 7..12.
  - limit = char_bits*64 BAUDTICKs (four character times); max 768, 10-bit counter.
  - The counter increments on BAUDTICK while FIFOEN=1 and COUNT>0.
  - It resets to 0 on push, pop or COUNT=0.
- TIMEOUT: set when the counter reaches limit; held at saturation. Clears on the same event that resets the counter.
- Reset mid-character: everything returns to reset values; no partial entry is retained.

Optional Feature:
UART_RX_FIFO_TIMEOUT_EN
- Defined: the timeout counter and TIMEOUT output are implemented as above.
- Undefined: TIMEOUT is tied to 0, the counter is not synthesised, and the WLS/STB/PEN/BAUDTICK inputs remain on the port but are unused.

Decomposition:
- Shared package uart_pkg:
  - rx_entry_t struct {bi,fe,pe,data[7:0]}.
  - Trigger-level encoding constants.
  - TIMEOUT_MULT=64.
- One sub-module, uart_rx_fifo_mem: DEPTH x 11-bit storage, wrap-around read/write pointers, count, full/empty. Controller logic (OE, FIFOERR, TRIG, timeout) stays in the top.

Test Plan:
- FIFOEN=1, push 0x41, 0x42, 0x43 -> COUNT=3, DR=1, RBR=0x41; after 3 RDs RBR sequence 0x41, 0x42, 0x43, then DR=0, COUNT=0.
- FIFOEN=1, push 17 characters with no RD -> COUNT=16, OE=1, 17th character absent from the FIFO; LSRRD -> OE=0; a further RD returns the 1st character.
- FIFOEN=0, push 0x55 then 0xAA with no RD -> RBR=0xAA, OE=1; same again with RD in the cycle of the 2nd push -> OE=0.
- Push 0x00 with BI_IN=FE_IN=1, then 0x33 clean -> FIFOERR=1, head BI=FE=1; RD -> head 0x33, BI=FE=0, FIFOERR=0.
- TRIGLVL=01, push 3 characters -> TRIG=0; 4th push -> TRIG=1 on the next cycle; one RD -> TRIG=0.
- Timeout (macro defined), WLS=11, PEN=0, STB=0 (char_bits=10), 1 character stored -> TIMEOUT=1 after exactly 640 BAUDTICKs; RD -> TIMEOUT=0. FIFOCLR mid-count -> COUNT=0, TIMEOUT stays 0.
